ca_vram_writer: RTL and testbench
=================================

# ca_vram_writer

Elementary cellular-automaton frame generator that is the write-side master of the 160x120 1-bit VRAM scanned out by the VGA block. It computes successive generations of a Wolfram rule over a wrap-around row of WIDTH cells and writes generation y to VRAM row y. One write per cell is issued on the VRAM write port (`write_addr`/`wdata`/`write_en`). It sits between the DE0 top level (rule, seed and override controls from DIP switches) and the VGA VRAM port.

## Interface
- WIDTH, 160, cells per row (even, >=4)
- HEIGHT, 120, rows per frame
- ADDR_W, 20, VRAM address width
- STEP_DIV, 4, clk cycles per cell write (>=2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to generate one frame; ignored while busy
- reseed  in  1  sampled with start: 1 = seed a fresh row, 0 = continue from the held row
- seed_mode  in  1  0 = single cell at WIDTH/2; 1 = pseudo-random row from the internal LFSR
- rule  in  8  Wolfram rule number; sampled with start, held for the whole frame
- suppress  in  1  forces written data to 0
- force  in  1  forces written data to 1; overrides suppress
- write_addr  out  ADDR_W  VRAM write address
- wdata  out  1  VRAM write data
- write_en  out  1  one-cycle write strobe
- busy  out  1  high from the cycle after an accepted start through the cycle of frame_done
- frame_done  out  1  one-cycle pulse after the last write of a frame

## Operation
- State registers: cur[WIDTH-1:0] (row being written), nxt[WIDTH-1:0] (next generation), x, y, address counter, divider, 16-bit LFSR.
- States:
  - IDLE: start -> SEED if reseed, else WRITE.
  - SEED: leads to WRITE.
  - WRITE: leads to DONE.
  - DONE: leads to IDLE.
- SEED, seed_mode=0: one cycle. cur is all zeros except cur[WIDTH/2]=1.
- SEED, seed_mode=1: WIDTH cycles. On cycle i, cur[i] <= LFSR bit 0, then the LFSR steps.
  - LFSR polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, reset value 16'hACE1.
  - The LFSR steps only in SEED.
- WRITE, per cell (x, y):
  - Address = y*WIDTH + x, held in an incrementing counter (no multiplier) and zero-extended. The frame starts at 0 and ends at WIDTH*HEIGHT-1.
  - Data = (cur[x] & ~suppress) | force. suppress/force are sampled live, not latched.
  - nxt[x] <= rule_q[{cur[x-1], cur[x], cur[x+1]}] (l,c,r index). Indices wrap: x-1 at x=0 is WIDTH-1; x+1 at x=WIDTH-1 is 0.
- After cell x=WIDTH-1: cur <= nxt, x <= 0, y++. After row HEIGHT-1 the copy also happens, so cur holds generation HEIGHT for a later continue. The FSM then goes to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- cur survives across frames. reset clears it to all zeros, so a continue after reset writes a blank frame.

## Timing
- Reset values: write_addr=0, wdata=0, write_en=0, busy=0, frame_done=0. Also state=IDLE and cur, nxt, x, y, divider = 0; LFSR=16'hACE1.
- Reset mid-frame aborts immediately with all of the above values. No partial write strobe is produced.
- Start accepted in IDLE at edge N: busy=1 from N+1. SEED/WRITE begins at N+1.
- Each cell occupies exactly STEP_DIV cycles:
  - write_addr/wdata are valid from the first cycle of the slot.
  - write_en is high on the last cycle only.
  - Consecutive strobes are exactly STEP_DIV cycles apart, including across row boundaries (no bubble).
- Frame length after the seed = WIDTH*HEIGHT*STEP_DIV cycles.
- frame_done is high the cycle after the final strobe. busy drops the cycle after that.
- write_en is never high outside WRITE. write_addr holds its last value in IDLE.
- start while busy is ignored, and is not queued.

## Test plan
- Reset: assert reset mid-frame -> same cycle all outputs 0; no write_en until the next start; busy low.
- rule=90, seed_mode=0, reseed=1, start:
  - Exactly 19200 write_en pulses, spaced 4 cycles, addresses 0..19199 in order.
  - addr 80 wdata=1; row 1 has 1 only at 239 and 241.
  - frame_done one cycle after the addr-19199 strobe; busy low the following cycle.
- Wrap-around: rule=0xAA (next = right neighbour), single seed -> row r has its single 1 at x=(80-r) mod 160. Row 80 at x=0, row 81 at x=159 (addr 81*160+159).
- Continue: repeat the wrap test, then start with reseed=0 -> new frame row 0 has its 1 at x=120 (generation 120).
- Overrides: suppress=1 -> all 19200 wdata=0; force=1 (with or without suppress) -> all 1. Toggling suppress mid-frame affects only subsequent cells.
- seed_mode=1 after reset -> SEED lasts 160 cycles. Row 0 matches the reference LFSR model from 16'hACE1. A start pulsed during WRITE changes nothing.

Source files
------------

// File: rtl/ca_vram_writer_if.sv
// Control inputs and VRAM write-port outputs of the cellular-automaton frame writer.
// master = the writer itself; slave = the side driving controls and consuming writes.
interface ca_vram_writer_if #(
    parameter int ADDR_W = 20
);
    logic              start;
    logic              reseed;
    logic              seed_mode;
    logic [7:0]        rule;
    logic              suppress;
    logic              force_one;
    logic [ADDR_W-1:0] write_addr;
    logic              wdata;
    logic              write_en;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, reseed, seed_mode, rule, suppress, force_one,
        output write_addr, wdata, write_en, busy, frame_done
    );

    modport slave (
        output start, reseed, seed_mode, rule, suppress, force_one,
        input  write_addr, wdata, write_en, busy, frame_done
    );
endinterface

// File: rtl/ca_vram_writer.sv
// Elementary CA frame generator: writes generation y to VRAM row y, one cell per STEP_DIV cycles.
// Seed takes 1 or WIDTH cycles after start; no backpressure, the VRAM port accepts every strobe.
module ca_vram_writer #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int ADDR_W   = 20,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    ca_vram_writer_if.master bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DW = $clog2(STEP_DIV);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_MID  = XW'(WIDTH / 2);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [DW-1:0] D_LAST = DW'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, SEED, WRITE, DONE} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  cur, nxt, nxt_upd;
    logic [XW-1:0]     x, x_l, x_r;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     div;
    logic [15:0]       lfsr;
    logic [7:0]        rule_q;
    logic              mode_q;
    logic              slot_end, row_end, frame_end, new_bit;

    // Wrap-around neighbourhood of the cell currently being written
    assign x_l       = (x == '0) ? X_LAST : x - XW'(1);
    assign x_r       = (x == X_LAST) ? '0 : x + XW'(1);
    assign new_bit   = rule_q[{cur[x_l], cur[x], cur[x_r]}];
    assign slot_end  = (state == WRITE) && (div == D_LAST);
    assign row_end   = slot_end && (x == X_LAST);
    assign frame_end = row_end && (y == Y_LAST);

    always_comb begin
        nxt_upd    = nxt;
        nxt_upd[x] = new_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = bus.reseed ? SEED : WRITE;
            SEED:    if (!mode_q || (x == X_LAST)) state_nx = WRITE;
            WRITE:   if (frame_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur    <= '0;
            nxt    <= '0;
            x      <= '0;
            y      <= '0;
            addr   <= '0;
            div    <= '0;
            lfsr   <= 16'hACE1;
            rule_q <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rule_q <= bus.rule;
                        mode_q <= bus.seed_mode;
                        x      <= '0;
                        y      <= '0;
                        addr   <= '0;
                        div    <= '0;
                    end
                end
                SEED: begin
                    if (!mode_q) begin
                        cur        <= '0;
                        cur[X_MID] <= 1'b1;
                    end else begin
                        // x doubles as the seed-cell index; taps 16,14,13,11
                        cur[x] <= lfsr[0];
                        lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                        x      <= (x == X_LAST) ? '0 : x + XW'(1);
                    end
                end
                WRITE: begin
                    if (div == D_LAST) begin
                        div    <= '0;
                        nxt[x] <= new_bit;
                        if (x == X_LAST) begin
                            cur <= nxt_upd;
                            x   <= '0;
                            y   <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                        // Leave the address on the final cell so IDLE shows the last write
                        if (!frame_end) addr <= addr + ADDR_W'(1);
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.write_addr = addr;
    assign bus.wdata      = (state == WRITE) && ((cur[x] && !bus.suppress) || bus.force_one);
    assign bus.write_en   = slot_end;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = (state == DONE);

endmodule

// File: tb/tb_ca_vram_writer.sv
// Directed bench for ca_vram_writer on a reduced 12x10 grid, STEP_DIV=3.
// Captures every strobe into an image and checks order, spacing, handshake timing and contents.
module tb_ca_vram_writer;
    localparam int W  = 12;
    localparam int H  = 10;
    localparam int SD = 3;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic reset;

    ca_vram_writer_if #(.ADDR_W(AW)) bus ();

    ca_vram_writer #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .ADDR_W  (AW),
        .STEP_DIV(SD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic img     [0:W*H-1];
    logic exp_img [0:W*H-1];
    int   strobes, bad_gap, bad_order, bad_range, done_gap, seed_len, timed_out;
    logic busy_first, busy_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ones(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) if (img[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int mism(input int a, input int b);
        int m = 0;
        for (int i = a; i < b; i++) if (img[i] !== exp_img[i]) m++;
        return m;
    endfunction

    // Reference evolution of a wrap-around elementary CA from a given row 0
    task automatic build_exp(input logic [W-1:0] row0, input logic [7:0] r);
        logic [W-1:0] c, n;
        c = row0;
        for (int yy = 0; yy < H; yy++) begin
            n = '0;
            for (int xx = 0; xx < W; xx++) begin
                exp_img[yy*W+xx] = c[xx];
                n[xx] = r[{c[(xx+W-1)%W], c[xx], c[(xx+1)%W]}];
            end
            c = n;
        end
    endtask

    task automatic run_frame(input bit rs, input bit sm, input logic [7:0] r,
                             input int tog, input int poke);
        int c, last, wa;
        strobes = 0; bad_gap = 0; bad_order = 0; bad_range = 0;
        done_gap = -1; seed_len = -1; timed_out = 0;
        busy_first = 1'b0; busy_after = 1'b1;
        last = 0; c = 0;
        for (int i = 0; i < W*H; i++) img[i] = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.reseed = rs; bus.seed_mode = sm; bus.rule = r;
        forever begin
            @(negedge clk);
            c++;
            bus.start = 1'b0;
            if (c == 1) busy_first = bus.busy;
            if (bus.write_en) begin
                wa = int'(bus.write_addr);
                if (strobes == 0) seed_len = c - SD;
                else if (c - last != SD) bad_gap++;
                if (wa != strobes) bad_order++;
                if (wa < W*H) img[wa] = bus.wdata;
                else bad_range++;
                strobes++;
                last = c;
                if (strobes == tog) bus.suppress = 1'b1;
                if (strobes == poke) bus.start = 1'b1;
            end
            if (bus.frame_done) begin
                done_gap = c - last;
                @(negedge clk);
                busy_after = bus.busy;
                break;
            end
            if (c > 4*W*H*SD) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic frame_checks(input string tag, input int exp_seed);
        chk({tag, ":timeout"},    timed_out, 0);
        chk({tag, ":strobes"},    strobes, W*H);
        chk({tag, ":gap"},        bad_gap, 0);
        chk({tag, ":order"},      bad_order, 0);
        chk({tag, ":range"},      bad_range, 0);
        chk({tag, ":seed_len"},   seed_len, exp_seed);
        chk({tag, ":busy_first"}, busy_first, 1);
        chk({tag, ":done_gap"},   done_gap, 1);
        chk({tag, ":busy_after"}, busy_after, 0);
    endtask

    logic [W-1:0] row0;
    logic [15:0]  lf;
    int           cnt;

    initial begin
        bus.start = 1'b0; bus.reseed = 1'b0; bus.seed_mode = 1'b0; bus.rule = '0;
        bus.suppress = 1'b0; bus.force_one = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst:addr",  bus.write_addr, 0);
        chk("rst:wdata", bus.wdata, 0);
        chk("rst:wen",   bus.write_en, 0);
        chk("rst:busy",  bus.busy, 0);
        chk("rst:done",  bus.frame_done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Rule 90 from a single centre cell
        run_frame(1'b1, 1'b0, 8'd90, -1, -1);
        frame_checks("r90", 1);
        chk("r90:idle_addr", bus.write_addr, W*H-1);
        chk("r90:seed_cell", img[6], 1);
        chk("r90:row0_ones", ones(0, W), 1);
        chk("r90:r1_x5",     img[W+5], 1);
        chk("r90:r1_x7",     img[W+7], 1);
        chk("r90:r1_ones",   ones(W, 2*W), 2);
        row0 = '0; row0[6] = 1'b1;
        build_exp(row0, 8'd90);
        chk("r90:model", mism(0, W*H), 0);

        // Rule 0xAA shifts the single cell left by one per row, wrapping
        run_frame(1'b1, 1'b0, 8'hAA, -1, -1);
        frame_checks("wrap", 1);
        chk("wrap:r6_x0",   img[6*W+0], 1);
        chk("wrap:r6_ones", ones(6*W, 7*W), 1);
        chk("wrap:r7_x11",  img[7*W+11], 1);
        chk("wrap:r7_ones", ones(7*W, 8*W), 1);
        build_exp(row0, 8'hAA);
        chk("wrap:model", mism(0, W*H), 0);

        // Continue: row 0 is generation 10, single cell at (6-10) mod 12 = 8
        run_frame(1'b0, 1'b0, 8'hAA, -1, -1);
        frame_checks("cont", 0);
        chk("cont:r0_x8",   img[8], 1);
        chk("cont:r0_ones", ones(0, W), 1);
        row0 = '0; row0[8] = 1'b1;
        build_exp(row0, 8'hAA);
        chk("cont:model", mism(0, W*H), 0);

        // Overrides
        bus.suppress = 1'b1;
        run_frame(1'b1, 1'b0, 8'd90, -1, -1);
        chk("sup:strobes", strobes, W*H);
        chk("sup:ones",    ones(0, W*H), 0);
        bus.force_one = 1'b1;
        run_frame(1'b1, 1'b0, 8'd90, -1, -1);
        chk("frc_sup:ones", ones(0, W*H), W*H);
        bus.suppress = 1'b0;
        run_frame(1'b1, 1'b0, 8'd90, -1, -1);
        chk("frc:ones", ones(0, W*H), W*H);
        bus.force_one = 1'b0;

        // suppress raised after the 60th strobe: only cells 60.. are blanked
        run_frame(1'b1, 1'b0, 8'd90, 60, -1);
        row0 = '0; row0[6] = 1'b1;
        build_exp(row0, 8'd90);
        chk("tog:before", mism(0, 60), 0);
        chk("tog:after",  ones(60, W*H), 0);
        bus.suppress = 1'b0;

        // Reset in the middle of a frame
        @(negedge clk);
        bus.start = 1'b1; bus.reseed = 1'b1; bus.seed_mode = 1'b0; bus.rule = 8'd90;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst:addr",  bus.write_addr, 0);
        chk("mid_rst:wdata", bus.wdata, 0);
        chk("mid_rst:wen",   bus.write_en, 0);
        chk("mid_rst:busy",  bus.busy, 0);
        chk("mid_rst:done",  bus.frame_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.write_en || bus.busy) cnt++;
        end
        chk("mid_rst:quiet", cnt, 0);

        // Continue after reset writes a blank frame
        run_frame(1'b0, 1'b0, 8'd90, -1, -1);
        frame_checks("blank", 0);
        chk("blank:ones", ones(0, W*H), 0);

        // LFSR seed from reset value, with an ignored start during WRITE
        run_frame(1'b1, 1'b1, 8'd30, -1, 30);
        frame_checks("rand", W);
        chk("rand:c0", img[0], 1);
        chk("rand:c1", img[1], 0);
        lf = 16'hACE1;
        for (int i = 0; i < W; i++) begin
            row0[i] = lf[0];
            lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
        end
        build_exp(row0, 8'd30);
        chk("rand:row0",  mism(0, W), 0);
        chk("rand:model", mism(0, W*H), 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.write_en || bus.busy) cnt++;
        end
        chk("rand:not_queued", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
